// File: rtl/thiele_coproc_arbiter_if.sv
// -----------------------------------------------------------------------------
// thiele_coproc_arbiter_if
// Purpose : Bundles the two CPU side-channels (logic-engine and Python) and the
//           single off-core coprocessor link that thiele_coproc_arbiter shares
//           between them, together with the status/accounting outputs.
// Modports:
//   master - arbiter view: takes requests and coprocessor responses in;
//            drives acks, response data, the coprocessor request and status out.
//   slave  - environment view (CPU + coprocessor): the mirror image.
// Signals :
//   logic_req/logic_addr -> logic_ack/logic_data     logic-engine channel
//   py_req/py_code_addr  -> py_ack/py_result          Python channel
//   cp_req/cp_sel/cp_addr <- cp_ack/cp_data           coprocessor link
//   busy, timeout_err, timeout_src,
//   grant_cnt_logic, grant_cnt_py                     status / accounting
// -----------------------------------------------------------------------------
interface thiele_coproc_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              logic_req;
  logic [ADDR_W-1:0] logic_addr;
  logic              logic_ack;
  logic [DATA_W-1:0] logic_data;

  logic              py_req;
  logic [ADDR_W-1:0] py_code_addr;
  logic              py_ack;
  logic [DATA_W-1:0] py_result;

  logic              cp_req;
  logic              cp_sel;
  logic [ADDR_W-1:0] cp_addr;
  logic              cp_ack;
  logic [DATA_W-1:0] cp_data;

  logic              busy;
  logic              timeout_err;
  logic              timeout_src;
  logic [CNT_W-1:0]  grant_cnt_logic;
  logic [CNT_W-1:0]  grant_cnt_py;

  modport master (
    input  logic_req, logic_addr, py_req, py_code_addr, cp_ack, cp_data,
    output logic_ack, logic_data, py_ack, py_result,
    output cp_req, cp_sel, cp_addr,
    output busy, timeout_err, timeout_src, grant_cnt_logic, grant_cnt_py
  );

  modport slave (
    output logic_req, logic_addr, py_req, py_code_addr, cp_ack, cp_data,
    input  logic_ack, logic_data, py_ack, py_result,
    input  cp_req, cp_sel, cp_addr,
    input  busy, timeout_err, timeout_src, grant_cnt_logic, grant_cnt_py
  );
endinterface

// File: rtl/thiele_coproc_arbiter.sv
// -----------------------------------------------------------------------------
// thiele_coproc_arbiter
// Purpose : Shares one external coprocessor channel between the CPU's blocking
//           logic-engine port and Python-execution port. Round-robin on ties,
//           bounded wait for the coprocessor response (a timeout returns
//           TIMEOUT_DATA and raises a sticky error), and saturating per-
//           requester grant counters for trace/receipt accounting.
// Ports   :
//   clk  - clock, everything on posedge
//   rst  - synchronous, active-high reset
//   bus  - thiele_coproc_arbiter_if.master (requester channels, coprocessor
//          link, status and grant counters)
// Flow    : IDLE -grant-> WAIT_CP -ack/timeout-> RESP (ack pulse) -> DRAIN
//           (wait for the served requester to drop req) -> IDLE.
// -----------------------------------------------------------------------------
module thiele_coproc_arbiter #(
  parameter int              ADDR_W         = 32,
  parameter int              DATA_W         = 32,
  parameter int              TIMEOUT_CYCLES = 256,
  parameter int              CNT_W          = 16,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = 32'hFFFF_FFFF
) (
  input  logic                     clk,
  input  logic                     rst,
  thiele_coproc_arbiter_if.master  bus
);

  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_CP = 2'd1,
    ST_RESP    = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  state_t            state_r;
  logic [TMO_W-1:0]  tmo_cnt_r;
  logic              last_grant_r;
  logic              cp_req_r;
  logic              cp_sel_r;
  logic [ADDR_W-1:0] cp_addr_r;
  logic              logic_ack_r;
  logic [DATA_W-1:0] logic_data_r;
  logic              py_ack_r;
  logic [DATA_W-1:0] py_result_r;
  logic              busy_r;
  logic              timeout_err_r;
  logic              timeout_src_r;
  logic [CNT_W-1:0]  grant_cnt_logic_r;
  logic [CNT_W-1:0]  grant_cnt_py_r;

  logic              grant_valid_s;
  logic              grant_sel_s;
  logic              served_req_s;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

  // Grant decision: single requester wins outright; on a tie the requester
  // that was not served last wins.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_sel_s   = 1'b0;
    if (bus.logic_req && bus.py_req) begin
      grant_valid_s = 1'b1;
      grant_sel_s   = ~last_grant_r;
    end else if (bus.logic_req) begin
      grant_valid_s = 1'b1;
      grant_sel_s   = 1'b0;
    end else if (bus.py_req) begin
      grant_valid_s = 1'b1;
      grant_sel_s   = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_sel_s   = 1'b0;
    end
  end

  // Request level of whichever requester is currently being served.
  always_comb begin
    served_req_s = 1'b0;
    if (cp_sel_r) begin
      served_req_s = bus.py_req;
    end else begin
      served_req_s = bus.logic_req;
    end
  end

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r           <= ST_IDLE;
      tmo_cnt_r         <= '0;
      last_grant_r      <= 1'b1;
      cp_req_r          <= 1'b0;
      cp_sel_r          <= 1'b0;
      cp_addr_r         <= '0;
      logic_ack_r       <= 1'b0;
      logic_data_r      <= '0;
      py_ack_r          <= 1'b0;
      py_result_r       <= '0;
      busy_r            <= 1'b0;
      timeout_err_r     <= 1'b0;
      timeout_src_r     <= 1'b0;
      grant_cnt_logic_r <= '0;
      grant_cnt_py_r    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          logic_ack_r <= 1'b0;
          py_ack_r    <= 1'b0;
          if (grant_valid_s) begin
            cp_req_r     <= 1'b1;
            cp_sel_r     <= grant_sel_s;
            cp_addr_r    <= grant_sel_s ? bus.py_code_addr : bus.logic_addr;
            last_grant_r <= grant_sel_s;
            tmo_cnt_r    <= '0;
            busy_r       <= 1'b1;
            state_r      <= ST_WAIT_CP;
            if (grant_sel_s) begin
              grant_cnt_py_r <= sat_inc(grant_cnt_py_r);
            end else begin
              grant_cnt_logic_r <= sat_inc(grant_cnt_logic_r);
            end
          end else begin
            busy_r <= 1'b0;
          end
        end

        ST_WAIT_CP: begin
          // cp_ack takes priority over expiry in the same cycle.
          if (bus.cp_ack) begin
            cp_req_r <= 1'b0;
            state_r  <= ST_RESP;
            if (cp_sel_r) begin
              py_result_r <= bus.cp_data;
              py_ack_r    <= 1'b1;
            end else begin
              logic_data_r <= bus.cp_data;
              logic_ack_r  <= 1'b1;
            end
          end else if (tmo_cnt_r == TMO_LAST) begin
            cp_req_r      <= 1'b0;
            timeout_err_r <= 1'b1;
            timeout_src_r <= cp_sel_r;
            state_r       <= ST_RESP;
            if (cp_sel_r) begin
              py_result_r <= TIMEOUT_DATA;
              py_ack_r    <= 1'b1;
            end else begin
              logic_data_r <= TIMEOUT_DATA;
              logic_ack_r  <= 1'b1;
            end
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end

        ST_RESP: begin
          // The ack was raised on entry; this closes the one-cycle pulse.
          logic_ack_r <= 1'b0;
          py_ack_r    <= 1'b0;
          state_r     <= ST_DRAIN;
        end

        ST_DRAIN: begin
          // Do not return to IDLE while the served request is still up,
          // otherwise it would be granted a second time.
          if (!served_req_s) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            busy_r  <= 1'b1;
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          cp_req_r    <= 1'b0;
          logic_ack_r <= 1'b0;
          py_ack_r    <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cp_req          = cp_req_r;
  assign bus.cp_sel          = cp_sel_r;
  assign bus.cp_addr         = cp_addr_r;
  assign bus.logic_ack       = logic_ack_r;
  assign bus.logic_data      = logic_data_r;
  assign bus.py_ack          = py_ack_r;
  assign bus.py_result       = py_result_r;
  assign bus.busy            = busy_r;
  assign bus.timeout_err     = timeout_err_r;
  assign bus.timeout_src     = timeout_src_r;
  assign bus.grant_cnt_logic = grant_cnt_logic_r;
  assign bus.grant_cnt_py    = grant_cnt_py_r;

endmodule

// File: tb/tb_thiele_coproc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_thiele_coproc_arbiter
// Directed bench for thiele_coproc_arbiter, built with TIMEOUT_CYCLES=8 and
// CNT_W=3 so that the timeout edge and counter saturation are reachable.
// -----------------------------------------------------------------------------
module tb_thiele_coproc_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TMO    = 8;
  localparam int CNT_W  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  thiele_coproc_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  thiele_coproc_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO),
    .CNT_W(CNT_W), .TIMEOUT_DATA(32'hFFFF_FFFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int n_lack = 0;
  int n_pack = 0;
  int n_creq = 0;

  // Cycle monitors: count edges at which each signal was high.
  always @(posedge clk) begin
    if (bus.logic_ack) n_lack <= n_lack + 1;
    if (bus.py_ack)    n_pack <= n_pack + 1;
    if (bus.cp_req)    n_creq <= n_creq + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.logic_req = 1'b0;
    bus.py_req    = 1'b0;
    bus.cp_ack    = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Serve one pending transaction, expecting requester sel; drops its req.
  task automatic serve(input logic sel, input logic [31:0] data,
                       input logic [31:0] addr, input string tag);
    for (int k = 0; k < 10 && !bus.cp_req; k++) tick();
    chk({tag, "_cpreq"}, bus.cp_req, 1);
    chk({tag, "_sel"}, bus.cp_sel, sel);
    chk({tag, "_addr"}, bus.cp_addr, addr);
    bus.cp_data = data;
    bus.cp_ack  = 1'b1;
    tick();
    bus.cp_ack  = 1'b0;
    if (sel) begin
      chk({tag, "_pyack"}, bus.py_ack, 1);
      chk({tag, "_lack0"}, bus.logic_ack, 0);
      chk({tag, "_pydata"}, bus.py_result, data);
      bus.py_req = 1'b0;
    end else begin
      chk({tag, "_lack"}, bus.logic_ack, 1);
      chk({tag, "_pyack0"}, bus.py_ack, 0);
      chk({tag, "_ldata"}, bus.logic_data, data);
      bus.logic_req = 1'b0;
    end
    for (int k = 0; k < 10 && bus.busy; k++) tick();
    chk({tag, "_idle"}, bus.busy, 0);
  endtask

  initial begin
    int l0;
    int p0;
    int c0;
    bus.logic_req    = 1'b0;
    bus.logic_addr   = 32'h0;
    bus.py_req       = 1'b0;
    bus.py_code_addr = 32'h0;
    bus.cp_ack       = 1'b0;
    bus.cp_data      = 32'h0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_cpreq", bus.cp_req, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_acks", {bus.logic_ack, bus.py_ack}, 2'b00);
    chk("rst_cnts", {bus.grant_cnt_logic, bus.grant_cnt_py}, 6'd0);
    chk("rst_err", bus.timeout_err, 0);
    chk("rst_ldata", bus.logic_data, 32'h0);
    rst = 1'b0;

    // cp_ack while idle is ignored.
    bus.cp_data = 32'hDEAD_BEEF;
    bus.cp_ack  = 1'b1;
    tick();
    bus.cp_ack  = 1'b0;
    chk("idle_ack_ign", bus.logic_ack, 0);
    chk("idle_data_ign", bus.logic_data, 32'h0);

    // Test 1: single logic request.
    bus.logic_req  = 1'b1;
    bus.logic_addr = 32'h40;
    tick();
    chk("t1_cpreq", bus.cp_req, 1);
    chk("t1_sel", bus.cp_sel, 0);
    chk("t1_addr", bus.cp_addr, 32'h40);
    chk("t1_cnt", bus.grant_cnt_logic, 1);
    bus.logic_addr = 32'h99;
    tick();
    tick();
    chk("t1_addr_frozen", bus.cp_addr, 32'h40);
    l0 = n_lack;
    p0 = n_pack;
    bus.cp_data = 32'hABCD_1234;
    bus.cp_ack  = 1'b1;
    tick();
    bus.cp_ack  = 1'b0;
    chk("t1_lack", bus.logic_ack, 1);
    chk("t1_ldata", bus.logic_data, 32'hABCD_1234);
    chk("t1_cpreq_drop", bus.cp_req, 0);
    bus.logic_req = 1'b0;
    tick();
    chk("t1_lack_off", bus.logic_ack, 0);
    tick();
    chk("t1_idle", bus.busy, 0);
    chk("t1_pulse_len", n_lack - l0, 1);
    chk("t1_no_pyack", n_pack - p0, 0);

    // Test 2: tie then alternation, then logic-only run to saturation.
    do_reset();
    bus.logic_addr   = 32'h100;
    bus.py_code_addr = 32'h200;
    bus.logic_req    = 1'b1;
    bus.py_req       = 1'b1;
    tick();
    serve(1'b0, 32'h0000_1111, 32'h100, "t2a");
    bus.logic_req = 1'b1;
    serve(1'b1, 32'h1234_5678, 32'h200, "t2b");
    bus.py_req = 1'b1;
    serve(1'b0, 32'h0000_2222, 32'h100, "t2c");
    bus.logic_req = 1'b1;
    serve(1'b1, 32'h1234_5678, 32'h200, "t2d");
    chk("t2_cnt_logic", bus.grant_cnt_logic, 2);
    chk("t2_cnt_py", bus.grant_cnt_py, 2);
    for (int i = 0; i < 6; i++) begin
      bus.logic_req = 1'b1;
      serve(1'b0, 32'h0000_3000 + 32'(i), 32'h100, "t2s");
    end
    chk("t2_sat_logic", bus.grant_cnt_logic, 7);
    chk("t2_sat_py", bus.grant_cnt_py, 2);

    // Test 5: held request after ack.
    do_reset();
    bus.logic_req  = 1'b1;
    bus.logic_addr = 32'h48;
    tick();
    chk("t5_cpreq", bus.cp_req, 1);
    bus.cp_data = 32'h0BAD_0005;
    bus.cp_ack  = 1'b1;
    tick();
    bus.cp_ack  = 1'b0;
    chk("t5_lack", bus.logic_ack, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_no_regrant", bus.cp_req, 0);
      chk("t5_busy_drain", bus.busy, 1);
    end
    bus.logic_req = 1'b0;
    tick();
    chk("t5_idle", bus.busy, 0);
    chk("t5_cnt", bus.grant_cnt_logic, 1);

    // Test 4: cp_ack in the final WAIT_CP cycle wins over expiry.
    bus.logic_req  = 1'b1;
    bus.logic_addr = 32'h44;
    tick();
    repeat (TMO - 1) tick();
    chk("t4_still_req", bus.cp_req, 1);
    bus.cp_data = 32'h5A5A_0001;
    bus.cp_ack  = 1'b1;
    tick();
    bus.cp_ack  = 1'b0;
    chk("t4_lack", bus.logic_ack, 1);
    chk("t4_ldata", bus.logic_data, 32'h5A5A_0001);
    chk("t4_no_err", bus.timeout_err, 0);
    bus.logic_req = 1'b0;
    tick();
    tick();
    chk("t4_idle", bus.busy, 0);

    // Test 3: Python timeout.
    bus.py_req       = 1'b1;
    bus.py_code_addr = 32'h80;
    c0 = n_creq;
    tick();
    chk("t3_cpreq", bus.cp_req, 1);
    for (int k = 0; k < 20 && bus.cp_req; k++) tick();
    chk("t3_req_cycles", n_creq - c0, TMO);
    chk("t3_pyack", bus.py_ack, 1);
    chk("t3_pyres", bus.py_result, 32'hFFFF_FFFF);
    chk("t3_err", bus.timeout_err, 1);
    chk("t3_src", bus.timeout_src, 1);
    chk("t3_ldata_kept", bus.logic_data, 32'h5A5A_0001);
    bus.py_req = 1'b0;
    tick();
    tick();
    chk("t3_idle", bus.busy, 0);
    chk("t3_err_sticky", bus.timeout_err, 1);

    // Test 6: reset during WAIT_CP.
    bus.py_req = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_in_wait", bus.cp_req, 1);
    p0 = n_pack;
    rst = 1'b1;
    bus.logic_req  = 1'b1;
    bus.logic_addr = 32'h4C;
    tick();
    chk("t6_cpreq", bus.cp_req, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_err_clr", bus.timeout_err, 0);
    chk("t6_cnts", {bus.grant_cnt_logic, bus.grant_cnt_py}, 6'd0);
    chk("t6_acks", {bus.logic_ack, bus.py_ack}, 2'b00);
    rst = 1'b0;
    tick();
    chk("t6_tie_logic", bus.cp_sel, 0);
    chk("t6_tie_addr", bus.cp_addr, 32'h4C);
    tick();
    tick();
    chk("t6_no_pyack", n_pack - p0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/thiele_coproc_arbiter.md
Name: thiele_coproc_arbiter

Overview:
- Shares one external coprocessor channel between the CPU's two blocking side-channels: the logic-engine port (logic_req/logic_addr/logic_ack/logic_data) and the Python-execution port (py_req/py_code_addr/py_ack/py_result).
- Sits between thiele_cpu and the single off-core coprocessor link.
- Provides round-robin arbitration, a response timeout, and per-requester grant counters for trace/receipt accounting.

Parameters:
- ADDR_W, 32, width of request address/code pointer
- DATA_W, 32, width of response data
- TIMEOUT_CYCLES, 256, cycles in WAIT_CP before forced completion (>=2)
- CNT_W, 16, width of grant counters
- TIMEOUT_DATA, 32'hFFFFFFFF, data returned on timeout

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous reset, active-high
- logic_req  in  1  logic-engine request, level, held until ack
- logic_addr  in  ADDR_W  logic request address
- logic_ack  out  1  one-cycle completion pulse
- logic_data  out  DATA_W  logic response
- py_req  in  1  Python request, level, held until ack
- py_code_addr  in  ADDR_W  Python code pointer
- py_ack  out  1  one-cycle completion pulse
- py_result  out  DATA_W  Python response
- cp_req  out  1  coprocessor request, held until cp_ack or timeout
- cp_sel  out  1  0 = logic, 1 = Python; stable while cp_req
- cp_addr  out  ADDR_W  latched address; stable while cp_req
- cp_ack  in  1  coprocessor completion, sampled only in WAIT_CP
- cp_data  in  DATA_W  response, valid with cp_ack
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky; set on any timeout, cleared only by rst
- timeout_src  out  1  cp_sel of the most recent timeout
- grant_cnt_logic  out  CNT_W  logic grants, saturating
- grant_cnt_py  out  CNT_W  Python grants, saturating

Behaviour:
- Reset values: every output is 0, state = IDLE, timeout counter = 0, last_grant = 1. With last_grant = 1, logic wins the first tie.
- States: IDLE, WAIT_CP, RESP, DRAIN. All outputs are registered.
- IDLE:
  - If only one of logic_req/py_req is high, grant it.
  - If both are high, grant the one that is not last_grant.
  - On grant: latch address into cp_addr, set cp_sel, set last_grant = cp_sel, increment that grant counter (hold at all-ones), clear the timeout counter, assert cp_req, go to WAIT_CP.
  - Latency: request seen at edge N gives cp_req high after edge N.
- WAIT_CP:
  - cp_req stays high; cp_addr and cp_sel are frozen.
  - The counter increments each cycle.
  - On cp_ack: capture cp_data into the selected response register (logic_data or py_result), drop cp_req, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 with no cp_ack: load TIMEOUT_DATA instead, set timeout_err, set timeout_src = cp_sel, drop cp_req, go to RESP.
  - If cp_ack arrives in the same cycle as expiry, cp_ack wins and no error is flagged.
- RESP:
  - Pulse the selected ack for exactly one cycle; the data register already holds its value.
  - Response registers hold their value until overwritten by a later grant to the same requester.
  - Go to DRAIN.
- DRAIN:
  - Wait until the granted requester's req is low, then go to IDLE.
  - This prevents re-serving a request the CPU has not yet dropped.
  - The other requester stays pending with no effect.
- General rules:
  - cp_ack outside WAIT_CP is ignored.
  - Address inputs are sampled only at grant.
  - Minimum service time is 4 cycles: grant, one WAIT_CP cycle, RESP, DRAIN.
  - A requester dropping req while in WAIT_CP does not abort the transaction; completion and the ack pulse still occur.
- Reset mid-operation: on the next edge cp_req, acks and counters return to reset values and state goes to IDLE. No ack is emitted for the aborted transaction. timeout_err is cleared.
- Grant counters wrap never; they saturate at 2^CNT_W-1.

Test Plan:
1. Single request: logic_req=1, logic_addr=0x40; cp_ack with cp_data=0xABCD1234 three cycles after cp_req -> cp_sel=0, cp_addr=0x40; logic_ack pulses one cycle after cp_ack with logic_data=0xABCD1234; grant_cnt_logic=1; py_ack stays 0.
2. Tie then alternation: logic_req and py_req both high from reset and re-raised after each drain -> grant order logic, py, logic, py; py_result=0x12345678 on Python grants; counters 2/2 after four transactions.
3. Timeout: py_req=1, no cp_ack, TIMEOUT_CYCLES=8 -> cp_req high for exactly 8 cycles; then py_ack with py_result=0xFFFFFFFF; timeout_err=1, timeout_src=1, held until rst.
4. Boundary: cp_ack asserted in the 8th WAIT_CP cycle (TIMEOUT_CYCLES=8) -> normal completion with cp_data returned; timeout_err stays 0.
5. Held request: logic_req held high 5 cycles past logic_ack -> no second cp_req; busy stays high in DRAIN; IDLE reached one cycle after logic_req falls; grant_cnt_logic=1.
6. Reset mid-op: rst=1 during WAIT_CP with timeout_err previously 1 -> after that edge cp_req=0, no ack pulse, all counters 0, timeout_err=0, and the next tie grants logic.
